status_fifo: RTL
================

STATUS_FIFO -- requirements
Module: status_fifo

Interface
REQ-001 SHALL have parameter DataWidth, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter Depth, default 16, entry count; power of two, >=2.
REQ-003 SHALL have parameter AlmostFullThresh, default 14, count at or above which almostFull asserts (1..Depth).
REQ-004 SHALL have parameter AlmostEmptyThresh, default 2, count at or below which almostEmpty asserts (0..Depth-1).
REQ-005 SHALL have parameter Fwft, default 1: 1 = first-word-fall-through read; 0 = registered read, 1-cycle latency.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port writeEN, input, 1, write request.
REQ-009 SHALL have port writeData, input, DataWidth, write word.
REQ-010 SHALL have port readEN, input, 1, read request.
REQ-011 SHALL have port clearErr, input, 1, clears sticky error flags.
REQ-012 SHALL have port readData, output, DataWidth, read word.
REQ-013 SHALL have port readValid, output, 1, readData qualifier.
REQ-014 SHALL have ports full, empty, almostFull, almostEmpty, output, 1 each, status flags.
REQ-015 SHALL have port count, output, $clog2(Depth)+1, current occupancy 0..Depth.
REQ-016 SHALL have ports overflow, underflow, output, 1 each, sticky error flags.

Function
REQ-017 SHALL use read/write pointers of $clog2(Depth)+1 bits; MSB is the wrap bit, low bits address memory; pointers wrap modulo 2*Depth.
REQ-018 SHALL accept a write only when writeEN && !full; the word is stored at the write address and wrPtr increments.
REQ-019 SHALL accept a read only when readEN && !empty; rdPtr increments.
REQ-020 SHALL decide full/empty acceptance from current-cycle flags: write while full is rejected even with a simultaneous read; read while empty is rejected even with a simultaneous write.
REQ-021 SHALL leave count unchanged when both a read and a write are accepted in one cycle; otherwise count changes by +1/-1.
REQ-022 SHALL drive empty = (count==0), full = (count==Depth), almostFull = (count>=AlmostFullThresh), almostEmpty = (count<=AlmostEmptyThresh), all derived from registered state.
REQ-023 With Fwft=1, readData SHALL combinationally show the head entry and readValid SHALL equal !empty; readEN acknowledges the head.
REQ-024 With Fwft=0, on an accepted read readData SHALL register the head entry and readValid SHALL be high the following cycle only; readData holds its value otherwise.
REQ-025 A rejected write SHALL set overflow; a rejected read SHALL set underflow; both remain set until clearErr or reset.
REQ-026 clearErr SHALL clear both flags next cycle; clearErr coincident with a new error SHALL leave the flag set.
REQ-027 Memory contents SHALL not be altered by rejected writes.

Reset
REQ-028 On rst_n low, pointers, count, readData, readValid, overflow, underflow SHALL go to 0 immediately, without waiting for clk.
REQ-029 After reset: empty=1, almostEmpty=1, full=0, almostFull=0; memory contents are don't-care and SHALL not be readable because empty=1.
REQ-030 Reset asserted mid-transfer SHALL discard all stored words; the first accepted write after release is the head.

Configuration
REQ-031 Macro STATUS_FIFO_ERR_FLAGS_EN: when defined, overflow/underflow/clearErr behave per REQ-025/026.
REQ-032 When STATUS_FIFO_ERR_FLAGS_EN is undefined, overflow and underflow SHALL be tied 0, clearErr ignored, no error-flag registers synthesized; all other behaviour unchanged.

Verification (DataWidth=8, Depth=16, thresholds 14/2, macro defined unless noted)
REQ-033 Reset then write 0x01..0x10 on 16 cycles -> count=16, full=1, almostFull from count=14; Fwft=1 reads return 0x01..0x10 in order, empty=1 after the 16th.
REQ-034 Full FIFO, writeEN=1 and readEN=1 same cycle with 0xAA -> read accepted, write rejected, count=15, overflow=1, 0xAA never read.
REQ-035 Empty FIFO, readEN=1 and writeEN=1 with 0x55 -> read rejected, underflow=1, count=1, readData=0x55 next cycle (Fwft=1); clearErr pulse -> underflow=0.
REQ-036 Count 8, continuous simultaneous read/write for 40 cycles (pointer wrap twice) -> count stays 8, data order preserved, no flags.
REQ-037 Fwft=0: write 0x3C, then readEN one cycle -> readValid=1 and readData=0x3C exactly one cycle later, readValid=0 after.
REQ-038 Macro undefined: read from empty -> underflow stays 0; rst_n low mid-burst at count=5 -> count=0, empty=1 asynchronously.

Source files
------------

// File: rtl/status_fifo.sv
// Synchronous status FIFO with occupancy count, threshold flags and optional FWFT read.
// Sticky overflow/underflow flags exist only when STATUS_FIFO_ERR_FLAGS_EN is defined.
module status_fifo #(
  parameter int DataWidth         = 8,
  parameter int Depth             = 16,
  parameter int AlmostFullThresh  = 14,
  parameter int AlmostEmptyThresh = 2,
  parameter int Fwft              = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       writeEN,
  input  logic [DataWidth-1:0]       writeData,
  input  logic                       readEN,
  input  logic                       clearErr,
  output logic [DataWidth-1:0]       readData,
  output logic                       readValid,
  output logic                       full,
  output logic                       empty,
  output logic                       almostFull,
  output logic                       almostEmpty,
  output logic [$clog2(Depth):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(Depth);
  localparam int PW = AW + 1;

  logic [DataWidth-1:0] r_mem [Depth];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [PW-1:0]        r_count;
  logic                 w_wr_acc;
  logic                 w_rd_acc;
  logic [AW-1:0]        w_wr_addr;
  logic [AW-1:0]        w_rd_addr;

  assign full        = (r_count == PW'(Depth));
  assign empty       = (r_count == '0);
  assign almostFull  = (r_count >= PW'(AlmostFullThresh));
  assign almostEmpty = (r_count <= PW'(AlmostEmptyThresh));
  assign count       = r_count;

  // Acceptance uses this cycle's flags, so a simultaneous read never frees room for a write.
  assign w_wr_acc  = writeEN && !full;
  assign w_rd_acc  = readEN && !empty;
  assign w_wr_addr = r_wr_ptr[AW-1:0];
  assign w_rd_addr = r_rd_ptr[AW-1:0];

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_wr_addr] <= writeData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  generate
    if (Fwft != 0) begin : g_fwft
      assign readData  = r_mem[w_rd_addr];
      assign readValid = !empty;
    end else begin : g_reg_read
      logic [DataWidth-1:0] r_read_data;
      logic                 r_read_valid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_read_data  <= '0;
          r_read_valid <= 1'b0;
        end else begin
          r_read_valid <= w_rd_acc;
          if (w_rd_acc) r_read_data <= r_mem[w_rd_addr];
        end
      end

      assign readData  = r_read_data;
      assign readValid = r_read_valid;
    end
  endgenerate

`ifdef STATUS_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // A new error wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (writeEN && full)      r_overflow <= 1'b1;
      else if (clearErr)        r_overflow <= 1'b0;
      if (readEN && empty)      r_underflow <= 1'b1;
      else if (clearErr)        r_underflow <= 1'b0;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  logic w_unused_clear_err;
  assign w_unused_clear_err = clearErr;
  assign overflow           = 1'b0;
  assign underflow          = 1'b0;
`endif

endmodule
